grf_write_sequencer: RTL and testbench

//   Drives the single GRF write port. Merges two producers:
//   - W-stage pipeline writes: always accepted, top priority.
//   - Side-channel results (e.g. multi-cycle MDU) via valid/ready into an in-order FIFO.

---
 rtl/grf_write_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_grf_write_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/grf_write_sequencer.sv
// grf_write_sequencer
// Owns the single write port of the general register file and merges two producers:
// W-stage writes, which always win, and side-channel results such as multi-cycle MDU
// results, which arrive through valid/ready and wait in an in-order FIFO. One registered
// write is presented to the register file per cycle. The block also reports which
// registers still have queued writes, for hazard detection. If W keeps the FIFO head
// blocked for too long, it requests a one-cycle W-stage stall.
//
// Ports
//   clk, rst_n                   clock and asynchronous active-low reset
//   w_we, w_a3, w_wd, w_pc       W-stage write; w_a3 == 0 is a no-op
//   s_valid, s_ready             side-channel handshake
//   s_a3, s_wd, s_pc             side-channel write payload; s_a3 == 0 is dropped
//   q_a1, q_a2, q_hit1, q_hit2   hazard queries against queued entries (combinational)
//   stall_w                      registered stall request to the W stage
//   cnt                          FIFO occupancy
//   grf_we, grf_a3, grf_wd       registered register file write
//   grf_pc                       PC of the write, for the trace
module grf_write_sequencer #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_we,
    input  logic [4:0]               w_a3,
    input  logic [31:0]              w_wd,
    input  logic [31:0]              w_pc,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [4:0]               s_a3,
    input  logic [31:0]              s_wd,
    input  logic [31:0]              s_pc,
    input  logic [4:0]               q_a1,
    input  logic [4:0]               q_a2,
    output logic                     q_hit1,
    output logic                     q_hit2,
    output logic                     stall_w,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     grf_we,
    output logic [4:0]               grf_a3,
    output logic [31:0]              grf_wd,
    output logic [31:0]              grf_pc
);

    localparam int AW    = $clog2(DEPTH);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]      CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);

    typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

    state_t            state, state_next;
    logic [AGE_W-1:0]  age, age_next;
    logic              stall_next;

    logic [4:0]        fifo_a3 [DEPTH];
    logic [31:0]       fifo_wd [DEPTH];
    logic [31:0]       fifo_pc [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DEPTH-1:0]  slot_valid;

    logic w_eff, fifo_empty, push, pop;

    // A full FIFO refuses new requests even when a pop happens in the same cycle.
    // This keeps s_ready independent of the W-stage inputs.
    assign s_ready    = rst_n && (cnt != CNT_FULL);
    assign w_eff      = w_we && (w_a3 != 5'd0);
    assign fifo_empty = (cnt == '0);
    assign push       = s_valid && s_ready && (s_a3 != 5'd0);
    assign pop        = !w_eff && !fifo_empty;

    // A physical slot holds a live entry when its distance from the read pointer is
    // less than the occupancy. This stops stale slot contents from producing hazard hits.
    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_valid
        logic [AW-1:0] off;
        assign off           = AW'(g) - rd_ptr;
        assign slot_valid[g] = ({1'b0, off} < cnt);
    end

    // Hazard lookup over live entries. The head that is being popped this cycle still
    // counts as a hit; the register file bypass covers the cycle after it.
    always_comb begin
        q_hit1 = 1'b0;
        q_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (q_a1 != 5'd0) && (fifo_a3[i] == q_a1)) q_hit1 = 1'b1;
            if (slot_valid[i] && (q_a2 != 5'd0) && (fifo_a3[i] == q_a2)) q_hit2 = 1'b1;
        end
    end

    // FIFO payload storage. It has no reset because the pointers and occupancy decide
    // which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a3[wr_ptr] <= s_a3;
            fifo_wd[wr_ptr] <= s_wd;
            fifo_pc[wr_ptr] <= s_pc;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Register file write port. W wins, otherwise the FIFO head drains. When idle, the
    // address, data and PC keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grf_we <= 1'b0;
            grf_a3 <= '0;
            grf_wd <= '0;
            grf_pc <= '0;
        end else begin
            grf_we <= w_eff || pop;
            if (w_eff) begin
                grf_a3 <= w_a3;
                grf_wd <= w_wd;
                grf_pc <= w_pc;
            end else if (pop) begin
                grf_a3 <= fifo_a3[rd_ptr];
                grf_wd <= fifo_wd[rd_ptr];
                grf_pc <= fifo_pc[rd_ptr];
            end
        end
    end

    // Starvation FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_NORMAL;
            age     <= '0;
            stall_w <= 1'b0;
        end else begin
            state   <= state_next;
            age     <= age_next;
            stall_w <= stall_next;
        end
    end

    // Next-state logic. The age counter counts edges on which a waiting head lost to W.
    // If W still writes while FORCE is active, the FSM stays in FORCE so that the stall holds.
    always_comb begin
        state_next = state;
        age_next   = age;
        case (state)
            ST_NORMAL: begin
                if (fifo_empty || pop) begin
                    age_next = '0;
                end else begin
                    age_next = age + 1'b1;
                    if (age_next == AGE_MAX) state_next = ST_FORCE;
                end
            end
            ST_FORCE: begin
                if (!w_eff) begin
                    state_next = ST_NORMAL;
                    age_next   = '0;
                end
            end
            default: begin
                state_next = ST_NORMAL;
                age_next   = '0;
            end
        endcase
    end

    // Output logic: the stall request follows FORCE and is registered with the state.
    always_comb begin
        stall_next = (state_next == ST_FORCE);
    end

endmodule

// File: tb/tb_grf_write_sequencer.sv
// Testbench for grf_write_sequencer. It applies directed vectors and compares the
// outputs with hand-computed values. Stimulus changes 1 ns after a rising edge, and
// outputs are checked after that as well.
module tb_grf_write_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        w_we;
    logic [4:0]  w_a3;
    logic [31:0] w_wd, w_pc;
    logic        s_valid, s_ready;
    logic [4:0]  s_a3;
    logic [31:0] s_wd, s_pc;
    logic [4:0]  q_a1, q_a2;
    logic        q_hit1, q_hit2, stall_w;
    logic [2:0]  cnt;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd, grf_pc;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    grf_write_sequencer #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc),
        .s_valid(s_valid), .s_ready(s_ready), .s_a3(s_a3), .s_wd(s_wd), .s_pc(s_pc),
        .q_a1(q_a1), .q_a2(q_a2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .stall_w(stall_w), .cnt(cnt),
        .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive both producers, then advance one rising edge plus 1 ns.
    task automatic applyStimulus(input logic we, input logic [4:0] wa3, input logic [31:0] wwd,
                                 input logic [31:0] wpc, input logic sv, input logic [4:0] sa3,
                                 input logic [31:0] swd, input logic [31:0] spc);
        w_we = we; w_a3 = wa3; w_wd = wwd; w_pc = wpc;
        s_valid = sv; s_a3 = sa3; s_wd = swd; s_pc = spc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        w_we = 0; w_a3 = 0; w_wd = 0; w_pc = 0;
        s_valid = 0; s_a3 = 0; s_wd = 0; s_pc = 0;
        q_a1 = 0; q_a2 = 0;
        @(posedge clk); @(posedge clk); #1;

        // Reset state.
        checkOutput("rst_grf_we", 32'(grf_we), 32'd0);
        checkOutput("rst_grf_a3", 32'(grf_a3), 32'd0);
        checkOutput("rst_cnt", 32'(cnt), 32'd0);
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_stall", 32'(stall_w), 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_s_ready", 32'(s_ready), 32'd1);

        // T1: W-stage write with a latency of one cycle, then an idle hold.
        applyStimulus(1, 5'd5, 32'h1234, 32'h3000, 0, 0, 0, 0);
        checkOutput("t1_we", 32'(grf_we), 32'd1);
        checkOutput("t1_a3", 32'(grf_a3), 32'd5);
        checkOutput("t1_wd", grf_wd, 32'h1234);
        checkOutput("t1_pc", grf_pc, 32'h3000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t1_idle_we", 32'(grf_we), 32'd0);
        checkOutput("t1_idle_a3_hold", 32'(grf_a3), 32'd5);

        // T2: side push, hazard visible while queued, drain on the next edge.
        q_a1 = 5'd8;
        #1;
        checkOutput("t2_hit_empty", 32'(q_hit1), 32'd0);
        applyStimulus(0, 0, 0, 0, 1, 5'd8, 32'hAA, 32'h4000);
        s_valid = 0;
        #1;
        checkOutput("t2_cnt1", 32'(cnt), 32'd1);
        checkOutput("t2_hit_queued", 32'(q_hit1), 32'd1);
        checkOutput("t2_no_bypass_we", 32'(grf_we), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_we", 32'(grf_we), 32'd1);
        checkOutput("t2_a3", 32'(grf_a3), 32'd8);
        checkOutput("t2_wd", grf_wd, 32'hAA);
        checkOutput("t2_pc", grf_pc, 32'h4000);
        checkOutput("t2_cnt0", 32'(cnt), 32'd0);
        checkOutput("t2_hit_gone", 32'(q_hit1), 32'd0);
        q_a1 = 0;

        // T3: W busy every cycle while four side entries fill the FIFO. The pointers
        // wrap here because they start at slot 1.
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 5'(10 + i), 32'(i), 32'h5000, 1, 5'(20 + i), 32'h100 + 32'(i), 32'h6000 + 32'(i));
        checkOutput("t3_cnt_full", 32'(cnt), 32'd4);
        checkOutput("t3_s_ready_full", 32'(s_ready), 32'd0);
        checkOutput("t3_w_last_a3", 32'(grf_a3), 32'd13);
        checkOutput("t3_starve_stall", 32'(stall_w), 32'd1);
        q_a2 = 5'd23;
        #1;
        checkOutput("t3_hit2_tail", 32'(q_hit2), 32'd1);
        // The request offered while full must be refused, even though the head pops.
        applyStimulus(0, 0, 0, 0, 1, 5'd30, 32'h300, 32'h7000);
        checkOutput("t3_drain0_a3", 32'(grf_a3), 32'd20);
        checkOutput("t3_drain0_wd", grf_wd, 32'h100);
        checkOutput("t3_cnt_after_full_pop", 32'(cnt), 32'd3);
        checkOutput("t3_stall_clear", 32'(stall_w), 32'd0);
        q_a2 = 5'd20; q_a1 = 5'd23;
        #1;
        checkOutput("t3_hit2_popped_stale", 32'(q_hit2), 32'd0);
        checkOutput("t3_hit1_live", 32'(q_hit1), 32'd1);
        q_a1 = 0; q_a2 = 0;
        for (int i = 1; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("t3_drain%0d_we", i), 32'(grf_we), 32'd1);
            checkOutput($sformatf("t3_drain%0d_a3", i), 32'(grf_a3), 32'(20 + i));
            checkOutput($sformatf("t3_drain%0d_pc", i), grf_pc, 32'h6000 + 32'(i));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t3_empty_we", 32'(grf_we), 32'd0);
        checkOutput("t3_empty_cnt", 32'(cnt), 32'd0);

        // T4: one queued entry is starved by W for three edges, then drained in FORCE.
        applyStimulus(1, 5'd1, 32'h11, 0, 1, 5'd7, 32'h77, 32'h8000);
        applyStimulus(1, 5'd2, 32'h22, 0, 0, 0, 0, 0);
        checkOutput("t4_blk1_stall", 32'(stall_w), 32'd0);
        applyStimulus(1, 5'd3, 32'h33, 0, 0, 0, 0, 0);
        checkOutput("t4_blk2_stall", 32'(stall_w), 32'd0);
        applyStimulus(1, 5'd4, 32'h44, 0, 0, 0, 0, 0);
        checkOutput("t4_blk3_stall", 32'(stall_w), 32'd1);
        checkOutput("t4_blk3_a3", 32'(grf_a3), 32'd4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t4_force_a3", 32'(grf_a3), 32'd7);
        checkOutput("t4_force_wd", grf_wd, 32'h77);
        checkOutput("t4_force_stall_off", 32'(stall_w), 32'd0);
        checkOutput("t4_cnt0", 32'(cnt), 32'd0);

        // T5: a W write to r0 never blocks the FIFO, and a side request to r0 is dropped.
        applyStimulus(1, 5'd0, 32'hDEAD, 0, 1, 5'd9, 32'h99, 32'h9000);
        checkOutput("t5_cnt1", 32'(cnt), 32'd1);
        applyStimulus(1, 5'd0, 32'hDEAD, 0, 0, 0, 0, 0);
        checkOutput("t5_we", 32'(grf_we), 32'd1);
        checkOutput("t5_a3", 32'(grf_a3), 32'd9);
        checkOutput("t5_wd", grf_wd, 32'h99);
        w_we = 0; s_valid = 1; s_a3 = 0; s_wd = 32'hBB;
        #1;
        checkOutput("t5_r0_ready", 32'(s_ready), 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'hBB, 0);
        checkOutput("t5_r0_cnt", 32'(cnt), 32'd0);
        checkOutput("t5_r0_we", 32'(grf_we), 32'd0);

        // T6: reset asserted in the middle of a cycle with three entries queued.
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 5'(1 + i), 0, 0, 1, 5'(24 + i), 0, 0);
        checkOutput("t6_cnt3", 32'(cnt), 32'd3);
        s_valid = 0; w_we = 0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_we", 32'(grf_we), 32'd0);
        checkOutput("t6_rst_cnt", 32'(cnt), 32'd0);
        checkOutput("t6_rst_ready", 32'(s_ready), 32'd0);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_post_we0", 32'(grf_we), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("t6_post_we1", 32'(grf_we), 32'd0);
        checkOutput("t6_post_cnt", 32'(cnt), 32'd0);
        checkOutput("t6_post_ready", 32'(s_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
